// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-voted sampling and a
// one-entry valid/ready output register reporting framing, parity and overrun.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 279,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(DATA_BITS);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] C_S1   = CW'(HALF);
    localparam logic [CW-1:0] C_S2   = CW'(HALF + 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
    state_t state, state_d;

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   s, smp_a, smp_b, perr_pend, ferr_pend;
    logic                   wrap, decide, maj, commit;

    assign s      = sync[SYNC_STAGES-1];
    assign wrap   = cnt == C_LAST;
    assign decide = cnt == C_S2;
    assign maj    = (smp_a & smp_b) | (smp_a & s) | (smp_b & s);
    // The final stop bit commits at its single mid-bit sample, not at bit end.
    assign commit = state == STOP && cnt == C_S1 && (STOP_BITS == 1 || idx == IW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (!s) state_d = START;
            START:   if (decide && maj) state_d = IDLE;
                     else if (wrap) state_d = DATA;
            DATA:    if (wrap && idx == I_LAST) state_d = (PARITY != 0) ? PAR : STOP;
            PAR:     if (wrap) state_d = STOP;
            STOP:    if (commit) state_d = s ? IDLE : BRK;
            BRK:     if (s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb busy = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= '1;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            smp_a      <= 1'b1;
            smp_b      <= 1'b1;
            perr_pend  <= 1'b0;
            ferr_pend  <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            cnt  <= (state == IDLE || state == BRK || wrap || commit) ? '0 : cnt + 1'b1;
            if (cnt == C_S0) smp_a <= s;
            if (cnt == C_S1) smp_b <= s;
            if (state == DATA && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (state == DATA && wrap) idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
            else if (state == STOP && wrap) idx <= idx + 1'b1;
            else if (state == IDLE || state == BRK) idx <= '0;
            if (state == START) begin
                perr_pend <= 1'b0;
                ferr_pend <= 1'b0;
            end
            if (state == PAR && decide) perr_pend <= maj != (^shreg ^ (PARITY == 2));
            if (state == STOP && cnt == C_S1 && !s) ferr_pend <= 1'b1;
            overrun <= commit && valid && !ready;
            if (commit && (!valid || ready)) begin
                data_out   <= shreg;
                frame_err  <= ferr_pend | !s;
                parity_err <= perr_pend;
                valid      <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames on three receiver
// configurations (8N1, 8E1, 7O2) checked against a frame-level model.
module tb_uart_rx_param;
    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int SYNC = 2;

    logic clk = 1'b0, rst = 1'b1, line = 1'b1, ready = 1'b1;
    int   sel = 0, cyc = 0, checks = 0, failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       din0, din1, din2, rdy0, rdy1, rdy2;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2, bz0, bz1, bz2;

    assign din0 = (sel == 0) ? line : 1'b1;
    assign din1 = (sel == 1) ? line : 1'b1;
    assign din2 = (sel == 2) ? line : 1'b1;
    assign rdy0 = (sel == 0) ? ready : 1'b1;
    assign rdy1 = (sel == 1) ? ready : 1'b1;
    assign rdy2 = (sel == 2) ? ready : 1'b1;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u0 (
        .clk(clk), .rst(rst), .din(din0), .ready(rdy0), .data_out(d0), .valid(v0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(bz0));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u1 (
        .clk(clk), .rst(rst), .din(din1), .ready(rdy1), .data_out(d1), .valid(v1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(bz1));
    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(SYNC)) u2 (
        .clk(clk), .rst(rst), .din(din2), .ready(rdy2), .data_out(d2), .valid(v2),
        .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .busy(bz2));

    logic [8:0] dq;
    logic       v, fe, pe, ov, bz;
    assign dq = (sel == 0) ? {1'b0, d0} : (sel == 1) ? {1'b0, d1} : {2'b0, d2};
    assign v  = (sel == 0) ? v0  : (sel == 1) ? v1  : v2;
    assign fe = (sel == 0) ? fe0 : (sel == 1) ? fe1 : fe2;
    assign pe = (sel == 0) ? pe0 : (sel == 1) ? pe1 : pe2;
    assign ov = (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
    assign bz = (sel == 0) ? bz0 : (sel == 1) ? bz1 : bz2;

    logic [10:0] got_q[$];
    int          rise_q[$];
    int          vcyc = 0, ov_cnt = 0, ov_cyc = 0;
    logic        v_prev = 1'b0;

    always @(negedge clk) begin
        if (v && ready) got_q.push_back({fe, pe, dq});
        if (v && !v_prev) rise_q.push_back(cyc);
        if (v) vcyc <= vcyc + 1;
        if (ov) begin
            ov_cnt <= ov_cnt + 1;
            ov_cyc <= cyc;
        end
        v_prev <= v;
    end

    int b_got, b_rise, b_v, b_ov;

    task automatic mark();
        b_got  = got_q.size();
        b_rise = rise_q.size();
        b_v    = vcyc;
        b_ov   = ov_cnt;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialises one frame on line; c is the cycle the start edge was driven.
    task automatic tx(input logic [8:0] w, input int nd, input int par, input int nst,
                      input bit badpar, input bit badstop, output int c);
        bit bits[$];
        logic [8:0] m;
        m = w & ((9'd1 << nd) - 9'd1);
        bits.push_back(1'b0);
        for (int i = 0; i < nd; i++) bits.push_back(m[i]);
        if (par != 0) bits.push_back(^m ^ (par == 2) ^ badpar);
        bits.push_back(!badstop);
        if (nst == 2) bits.push_back(1'b1);
        c = cyc;
        foreach (bits[i]) begin
            line = bits[i];
            tick(CPB);
        end
        line = 1'b1;
    endtask

    task automatic frame(input int k, input logic [8:0] w, input int nd, input int par,
                         input int nst, input bit badpar, input bit badstop);
        int c, n;
        logic [10:0] g;
        logic [8:0] m;
        sel   = k;
        ready = 1'b1;
        m     = w & ((9'd1 << nd) - 9'd1);
        n     = nd + (par != 0) + nst;
        mark();
        tx(w, nd, par, nst, badpar, badstop, c);
        tick(HALF + 4);
        g = (got_q.size() > b_got) ? got_q[b_got] : 'x;
        chk("words", got_q.size() - b_got, 1);
        chk("data", g[8:0], m);
        chk("frame_err", g[10], badstop);
        chk("parity_err", g[9], (par != 0) && badpar);
        chk("latency", (rise_q.size() > b_rise) ? rise_q[b_rise] - c : -1, SYNC + n * CPB + HALF + 2);
        chk("valid_cycles", vcyc - b_v, 1);
        chk("no_overrun", ov_cnt - b_ov, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        int c1, c2, c;
        logic [7:0] r;
        tick(3);
        chk("rst_valid", {v0, v1, v2}, 3'b000);
        chk("rst_busy", {bz0, bz1, bz2}, 3'b000);
        chk("rst_data", {d0, d1, d2}, 23'd0);
        chk("rst_flags", {fe0, pe0, ov0, fe1, pe1, ov1, fe2, pe2, ov2}, 9'd0);
        rst = 1'b0;
        tick(4);
        chk("idle_busy", bz, 1'b0);

        frame(0, 9'h0A5, 8, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) frame(0, 9'($urandom_range(0, 255)), 8, 0, 1, 0, $urandom_range(0, 1));
        tick(5);

        // back-to-back with consumer stalled: second frame is dropped
        sel = 0;
        ready = 1'b0;
        mark();
        tx(9'h03C, 8, 0, 1, 0, 0, c1);
        tx(9'h0C3, 8, 0, 1, 0, 0, c2);
        while (cyc < c2 + SYNC + 9 * CPB + HALF + 1 + 20) tick(1);
        chk("ovr_count", ov_cnt - b_ov, 1);
        chk("ovr_cycle", ov_cyc - c2, SYNC + 9 * CPB + HALF + 2);
        chk("ovr_held_valid", v, 1'b1);
        chk("ovr_held_data", dq, 9'h03C);
        ready = 1'b1;
        tick(1);
        chk("ovr_drop_valid", v, 1'b0);
        chk("ovr_words", got_q.size() - b_got, 1);
        chk("ovr_word", (got_q.size() > b_got) ? got_q[b_got] : 'x, {2'b00, 9'h03C});
        tick(4);

        frame(1, 9'h007, 8, 1, 1, 0, 0);
        frame(1, 9'h007, 8, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) frame(1, 9'($urandom_range(0, 255)), 8, 1, 1, $urandom_range(0, 1), 0);

        // short glitch aborts at the start-bit decision cycle
        sel = 0;
        mark();
        c = cyc;
        line = 1'b0;
        tick(4);
        line = 1'b1;
        while (cyc < c + SYNC + 1 + HALF + 1) tick(1);
        chk("glitch_busy", bz, 1'b1);
        tick(1);
        chk("glitch_abort", bz, 1'b0);
        tick(20);
        chk("glitch_words", got_q.size() - b_got, 0);
        chk("glitch_valid", rise_q.size() - b_rise, 0);

        // held-low line: one 0x00 word with frame error, then held in break
        mark();
        line = 1'b0;
        tick(30 * CPB);
        chk("brk_words", got_q.size() - b_got, 1);
        chk("brk_word", (got_q.size() > b_got) ? got_q[b_got] : 'x, {2'b10, 9'h000});
        chk("brk_busy", bz, 1'b1);
        line = 1'b1;
        tick(10);
        chk("brk_idle", bz, 1'b0);
        frame(0, 9'h055, 8, 0, 1, 0, 0);

        // async reset mid-DATA with a word pending
        ready = 1'b0;
        r = 8'($urandom_range(1, 255));
        tx({1'b0, r}, 8, 0, 1, 0, 0, c);
        tick(4);
        chk("pend_data", dq, {1'b0, r});
        line = 1'b0;
        tick(CPB);
        line = 1'b1;
        tick(CPB);
        line = 1'b0;
        tick(HALF);
        chk("pre_rst_busy", bz, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_valid", v, 1'b0);
        chk("arst_data", dq, 9'h000);
        chk("arst_busy", bz, 1'b0);
        chk("arst_flags", {fe, pe, ov}, 3'b000);
        tick(1);
        rst = 1'b0;
        line = 1'b1;
        ready = 1'b1;
        tick(5);
        frame(0, 9'h042, 8, 0, 1, 0, 0);

        frame(2, 9'h05A, 7, 2, 2, 0, 0);
        for (int i = 0; i < 2; i++) frame(2, 9'($urandom_range(0, 127)), 7, 2, 2, $urandom_range(0, 1), $urandom_range(0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
